// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer: op encodings and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    SLL  = OP_SLL,
    SRL  = OP_SRL,
    SRA  = OP_SRA,
    RSVD = OP_RSVD
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT2 = 2'b01,
    SHIFT1 = 2'b10,
    DONE   = 2'b11
  } shift_state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Start/result bus between the control unit and the shift sequencer.
interface shift_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   y;

  modport master (output start, op, a, shamt, input busy, done, y);
  modport slave  (input start, op, a, shamt, output busy, done, y);
endinterface

// File: rtl/shift_step.sv
// One fixed-size shift step (1 or 2 bits); SRA replicates the current MSB.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] w,
  input  shift_op_t        op,
  input  logic             by2,
  output logic [WIDTH-1:0] w_nxt
);

  always_comb begin
    w_nxt = w;
    case (op)
      SLL: w_nxt = by2 ? {w[WIDTH-3:0], 2'b00} : {w[WIDTH-2:0], 1'b0};
      SRL: w_nxt = by2 ? {2'b00, w[WIDTH-1:2]} : {1'b0, w[WIDTH-1:1]};
      SRA: w_nxt = by2 ? {{2{w[WIDTH-1]}}, w[WIDTH-1:2]} : {w[WIDTH-1], w[WIDTH-1:1]};
      default: w_nxt = w;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: shift-by-2 steps plus at most one shift-by-1,
// with a single-cycle done pulse and the result held on y until the next start.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  shift_seq_if.slave  bus
);

  shift_state_t       state, state_n;
  shift_op_t          op_q, op_n, op_in;
  logic [WIDTH-1:0]   w, w_n, w_step;
  logic [SHAMT_W-1:0] rem, rem_n, rem_dec;
  logic               by2;

  assign op_in   = shift_op_t'(bus.op);
  assign rem_dec = rem - SHAMT_W'(2);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w     (w),
    .op    (op_q),
    .by2   (by2),
    .w_nxt (w_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= SLL;
      w     <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      w     <= w_n;
      rem   <= rem_n;
    end
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    w_n     = w;
    rem_n   = rem;
    by2     = 1'b1;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_n   = bus.a;
          rem_n = bus.shamt;
          op_n  = op_in;
          // Reserved op and zero shift both bypass the step states.
          if (op_in == RSVD || bus.shamt == '0)   state_n = DONE;
          else if (bus.shamt >= SHAMT_W'(2))      state_n = SHIFT2;
          else                                    state_n = SHIFT1;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT2: begin
        w_n   = w_step;
        rem_n = rem_dec;
        if (rem_dec >= SHAMT_W'(2))      state_n = SHIFT2;
        else if (rem_dec == SHAMT_W'(1)) state_n = SHIFT1;
        else                             state_n = DONE;
      end
      SHIFT1: begin
        by2     = 1'b0;
        w_n     = w_step;
        rem_n   = '0;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state == SHIFT2) || (state == SHIFT1);
  assign bus.done = (state == DONE);
  assign bus.y    = w;

endmodule
